display_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 4-digit common-anode 7-segment stopwatch display (digits min_l, min_r, sec_l, sec_r).
- Sequences one digit per slot, inserts anti-ghosting dead time and decodes BCD to active-low segments.
- Applies 1 Hz adjust-mode blinking per digit and snapshots the digit values once per frame so a frame is never torn.
- Sits between the stopwatch counters and the board anode/segment pins.

---
 rtl/display_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit 7-segment scan controller with dead time, blink and frame snapshot
module display_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       adj,
    input  logic       blink,
    input  logic [3:0] blink_mask,
    input  logic [3:0] min_l,
    input  logic [3:0] min_r,
    input  logic [3:0] sec_l,
    input  logic [3:0] sec_r,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    shadow_q, shadow_d;
    logic           snap;
    logic [3:0]     digit;
    logic           blanked;
    logic [3:0]     an_d;
    logic [6:0]     seg_d;
    logic           dp_d;
    logic           frame_done_d;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        snap         = 1'b0;
        frame_done_d = 1'b0;
        if (!en) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    snap  = (cnt_q == '0) && (idx_q == 2'd0);
                    if (cnt_q == BLANK_LAST) state_d = SHOW;
                end
                SHOW: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d      = BLANK;
                        cnt_d        = '0;
                        idx_d        = idx_q + 2'd1;
                        frame_done_d = (idx_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next-state view so they line up with state_q.
    always_comb begin
        shadow_d = snap ? {min_l, min_r, sec_l, sec_r} : shadow_q;
        case (idx_d)
            2'd0:    digit = shadow_d[15:12];
            2'd1:    digit = shadow_d[11:8];
            2'd2:    digit = shadow_d[7:4];
            default: digit = shadow_d[3:0];
        endcase
        blanked = adj && !blink && blink_mask[2'd3 - idx_d];
        an_d    = 4'b1111;
        seg_d   = 7'b1111111;
        dp_d    = 1'b1;
        if (state_d == SHOW) begin
            an_d = ~(4'b1000 >> idx_d);
            if (!blanked) begin
                seg_d = decode(digit);
                dp_d  = (idx_d != 2'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            shadow_q   <= '0;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       adj;
    logic       blink;
    logic [3:0] blink_mask;
    logic [3:0] min_l;
    logic [3:0] min_r;
    logic [3:0] sec_l;
    logic [3:0] sec_r;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    int         checks_total;
    int         checks_passed;
    logic [3:0] dig [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_fd;

    display_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .adj(adj), .blink(blink),
        .blink_mask(blink_mask), .min_l(min_l), .min_r(min_r),
        .sec_l(sec_l), .sec_r(sec_r), .an(an), .seg(seg), .dp(dp),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: seg_of = 7'b1000000;
            4'd1: seg_of = 7'b1111001;
            4'd2: seg_of = 7'b0100100;
            4'd3: seg_of = 7'b0110000;
            4'd4: seg_of = 7'b0011001;
            4'd5: seg_of = 7'b0010010;
            4'd6: seg_of = 7'b0000010;
            4'd7: seg_of = 7'b1111000;
            4'd8: seg_of = 7'b0000000;
            4'd9: seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    // Leaves the DUT in IDLE with en just raised; the next negedge is BLANK cycle 0 of slot 0.
    task automatic restart(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] d, input logic ad, input logic bl, input logic [3:0] m);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        min_l = a; min_r = b; sec_l = c; sec_r = d;
        dig[0] = a; dig[1] = b; dig[2] = c; dig[3] = d;
        adj = ad; blink = bl; blink_mask = m;
        en = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en = 1'b0; adj = 1'b0; blink = 1'b1; blink_mask = 4'b0000;
        min_l = 4'd0; min_r = 4'd0; sec_l = 4'd0; sec_r = 4'd0;
        repeat (3) @(negedge clk);
        checks_total++;
        if ({an, seg, dp, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0})
            $display("FAIL reset_outputs: got an=%b seg=%b dp=%b fd=%b expected 1111 1111111 1 0",
                     an, seg, dp, frame_done);
        else checks_passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks_total++;
        if (an !== 4'b1111) $display("FAIL idle_dark: got an=%b expected 1111", an);
        else checks_passed++;
    endtask

    task automatic test_scan;
        restart(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 4'b0000);
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < 4; s++)
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    exp_an  = (c < 2) ? 4'b1111 : ~(4'b1000 >> s);
                    exp_seg = (c < 2) ? 7'b1111111 : seg_of(dig[s]);
                    exp_dp  = (c >= 2 && s == 1) ? 1'b0 : 1'b1;
                    exp_fd  = (f == 1 && s == 0 && c == 0);
                    checks_total++;
                    if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd})
                        $display("FAIL scan f%0d s%0d c%0d: got an=%b seg=%b dp=%b fd=%b expected an=%b seg=%b dp=%b fd=%b",
                                 f, s, c, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
                    else checks_passed++;
                end
    endtask

    task automatic test_snapshot;
        restart(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 4'b0000);
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < 4; s++)
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    if (c >= 2) begin
                        exp_seg = (s == 3) ? ((f == 0) ? 7'b0011001 : 7'b0010000) : seg_of(dig[s]);
                        checks_total++;
                        if (seg !== exp_seg)
                            $display("FAIL snapshot f%0d s%0d c%0d: got seg=%b expected %b", f, s, c, seg, exp_seg);
                        else checks_passed++;
                    end
                    if (f == 0 && s == 1 && c == 3) sec_r = 4'd9;
                end
    endtask

    task automatic test_blink_decode;
        logic [3:0] bmask;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin restart(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0, 4'b0011); bmask = 4'b0011; end
                1: begin restart(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b1, 4'b0011); bmask = 4'b0000; end
                2: begin restart(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 4'b1111); bmask = 4'b0000; end
                default: begin restart(4'd12, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0, 4'b0100); bmask = 4'b0100; end
            endcase
            for (int s = 0; s < 4; s++)
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    exp_an  = (c < 2) ? 4'b1111 : ~(4'b1000 >> s);
                    exp_seg = (c < 2 || bmask[3-s]) ? 7'b1111111 : seg_of(dig[s]);
                    exp_dp  = (c >= 2 && s == 1 && !bmask[3-s]) ? 1'b0 : 1'b1;
                    checks_total++;
                    if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp})
                        $display("FAIL blink k%0d s%0d c%0d: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                                 k, s, c, an, seg, dp, exp_an, exp_seg, exp_dp);
                    else checks_passed++;
                end
        end
    endtask

    task automatic test_en_drop;
        restart(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 4'b0000);
        repeat (21) @(negedge clk);
        checks_total++;
        if (an !== 4'b1101) $display("FAIL en_drop_pre: got an=%b expected 1101", an);
        else checks_passed++;
        en = 1'b0;
        @(negedge clk);
        checks_total++;
        if ({an, seg, dp, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0})
            $display("FAIL en_drop_dark: got an=%b seg=%b dp=%b fd=%b expected 1111 1111111 1 0",
                     an, seg, dp, frame_done);
        else checks_passed++;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks_total++;
            if ({an, frame_done} !== {4'b1111, 1'b0})
                $display("FAIL en_drop_idle %0d: got an=%b fd=%b expected 1111 0", i, an, frame_done);
            else checks_passed++;
        end
        en = 1'b1;
        @(negedge clk);
        checks_total++;
        if ({an, frame_done} !== {4'b1111, 1'b0})
            $display("FAIL en_restart_blank: got an=%b fd=%b expected 1111 0", an, frame_done);
        else checks_passed++;
        repeat (2) @(negedge clk);
        checks_total++;
        if ({an, seg} !== {4'b0111, 7'b1111001})
            $display("FAIL en_restart_slot0: got an=%b seg=%b expected 0111 1111001", an, seg);
        else checks_passed++;
    endtask

    task automatic test_async_reset;
        restart(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 4'b0000);
        repeat (12) @(negedge clk);
        checks_total++;
        if (an !== 4'b1011) $display("FAIL rst_pre: got an=%b expected 1011", an);
        else checks_passed++;
        #2 rst_n = 1'b0;
        #1;
        checks_total++;
        if ({an, seg, dp, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0})
            $display("FAIL rst_async_dark: got an=%b seg=%b dp=%b fd=%b expected 1111 1111111 1 0",
                     an, seg, dp, frame_done);
        else checks_passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks_total++;
        if ({an, seg} !== {4'b0111, 7'b1111001})
            $display("FAIL rst_first_slot: got an=%b seg=%b expected 0111 1111001", an, seg);
        else checks_passed++;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        test_reset();
        test_scan();
        test_snapshot();
        test_blink_decode();
        test_en_drop();
        test_async_reset();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
